// File: rtl/wb_ppfifo_2_mem_bank_ctrl.sv
// Descriptor queue plus ping-pong bank sequencer for the ppfifo-to-memory writer.
// Loads (base, size) into bank 0/1 alternately and reports each bank's completion.
module wb_ppfifo_2_mem_bank_ctrl #(
  parameter int DESC_DEPTH = 4,
  parameter int DESC_AW    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_enable,
  input  logic               i_flush,
  input  logic               i_desc_stb,
  input  logic [31:0]        i_desc_base,
  input  logic [31:0]        i_desc_size,
  output logic [DESC_AW:0]   o_desc_count,
  output logic               o_desc_full,
  output logic               o_desc_err,
  output logic [31:0]        o_memory_0_base,
  output logic [31:0]        o_memory_1_base,
  output logic [31:0]        o_memory_0_size,
  output logic [31:0]        o_memory_1_size,
  output logic               o_memory_0_ready,
  output logic               o_memory_1_ready,
  input  logic               i_memory_0_finished,
  input  logic               i_memory_1_finished,
  output logic               o_done_stb,
  output logic               o_done_bank,
  output logic [31:0]        o_done_size,
  output logic [7:0]         o_done_count,
  input  logic               i_done_ack,
  output logic               o_interrupt,
  output logic               o_busy
);

  localparam logic [DESC_AW:0] L_DEPTH = (DESC_AW + 1)'(DESC_DEPTH);

  typedef enum logic [2:0] {
    BANK_FREE   = 3'd0,
    BANK_LOAD   = 3'd1,
    BANK_ARM    = 3'd2,
    BANK_ACTIVE = 3'd3,
    BANK_RETIRE = 3'd4
  } bank_state_t;

  logic [31:0]        r_q_base [DESC_DEPTH];
  logic [31:0]        r_q_size [DESC_DEPTH];
  logic [DESC_AW-1:0] r_wr_ptr;
  logic [DESC_AW-1:0] r_rd_ptr;
  logic [DESC_AW:0]   r_count;
  logic               r_desc_err;

  bank_state_t        r_state [2];
  bank_state_t        w_state_nxt [2];
  logic [31:0]        r_base [2];
  logic [31:0]        r_size [2];
  logic [1:0]         r_ready;
  logic               r_next_bank;
  logic [7:0]         r_done_count;

  logic               w_q_full;
  logic               w_q_empty;
  logic               w_push;
  logic               w_pop;
  logic [1:0]         w_load;
  logic [1:0]         w_free;
  logic [1:0]         w_retire;
  logic [1:0]         w_report;
  logic [1:0]         w_fin;

  assign w_q_full  = (r_count == L_DEPTH);
  assign w_q_empty = (r_count == '0);
  assign w_fin     = {i_memory_1_finished, i_memory_0_finished};
  assign w_pop     = |w_load;
  // A pop in the same cycle frees a slot, so a push into a full queue still lands.
  assign w_push    = i_desc_stb && (i_desc_size != 32'd0) && (!w_q_full || w_pop) && !i_flush;

  // Per-bank status decode; bank 0 wins when both retire together.
  always_comb begin
    w_free   = 2'b00;
    w_retire = 2'b00;
    for (int b = 0; b < 2; b++) begin
      w_free[b]   = (r_state[b] == BANK_FREE);
      w_retire[b] = (r_state[b] == BANK_RETIRE);
    end
    w_report[0] = w_retire[0];
    w_report[1] = w_retire[1] && !w_retire[0];
  end

  // Dispatch: prefer the pointed-to bank, fall back to the other one.
  always_comb begin
    w_load = 2'b00;
    if (i_enable && !w_q_empty && !i_flush) begin
      if (w_free[r_next_bank]) begin
        w_load[r_next_bank] = 1'b1;
      end else if (w_free[~r_next_bank]) begin
        w_load[~r_next_bank] = 1'b1;
      end else begin
        w_load = 2'b00;
      end
    end else begin
      w_load = 2'b00;
    end
  end

  // Bank FSM next state; ARM masks a stale finished left over from the previous load.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_state_nxt[b] = r_state[b];
      case (r_state[b])
        BANK_FREE:   w_state_nxt[b] = w_load[b] ? BANK_LOAD : BANK_FREE;
        BANK_LOAD:   w_state_nxt[b] = BANK_ARM;
        BANK_ARM:    w_state_nxt[b] = BANK_ACTIVE;
        BANK_ACTIVE: w_state_nxt[b] = w_fin[b] ? BANK_RETIRE : BANK_ACTIVE;
        BANK_RETIRE: w_state_nxt[b] = w_report[b] ? BANK_FREE : BANK_RETIRE;
        default:     w_state_nxt[b] = BANK_FREE;
      endcase
    end
  end

  // Descriptor storage (no reset needed, guarded by the pointers).
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_base[r_wr_ptr] <= i_desc_base;
      r_q_size[r_wr_ptr] <= i_desc_size;
    end
  end

  // Queue pointers, occupancy and drop pulse.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_desc_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_desc_err <= i_desc_stb && !w_push;
    end
  end

  // Bank state, loaded descriptor and the one-cycle ready pulse.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      for (int b = 0; b < 2; b++) begin
        r_state[b] <= BANK_FREE;
        r_base[b]  <= 32'd0;
        r_size[b]  <= 32'd0;
      end
      r_ready     <= 2'b00;
      r_next_bank <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        r_state[b] <= w_state_nxt[b];
        if (w_load[b]) begin
          r_base[b] <= r_q_base[r_rd_ptr];
          r_size[b] <= r_q_size[r_rd_ptr];
        end else if (w_report[b]) begin
          r_size[b] <= 32'd0;
        end
      end
      r_ready <= w_load;
      if (w_pop) begin
        r_next_bank <= w_load[0];
      end
    end
  end

  // Unacknowledged completion counter; flush leaves it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done_count <= 8'd0;
    end else if (i_flush) begin
      r_done_count <= r_done_count;
    end else begin
      case ({|w_report, i_done_ack})
        2'b10:   r_done_count <= (r_done_count == 8'hFF) ? r_done_count : r_done_count + 8'd1;
        2'b01:   r_done_count <= (r_done_count == 8'd0) ? r_done_count : r_done_count - 8'd1;
        default: r_done_count <= r_done_count;
      endcase
    end
  end

  assign o_desc_count     = r_count;
  assign o_desc_full      = w_q_full;
  assign o_desc_err       = r_desc_err;
  assign o_memory_0_base  = r_base[0];
  assign o_memory_1_base  = r_base[1];
  assign o_memory_0_size  = r_size[0];
  assign o_memory_1_size  = r_size[1];
  assign o_memory_0_ready = r_ready[0];
  assign o_memory_1_ready = r_ready[1];
  assign o_done_stb       = |w_report;
  assign o_done_bank      = w_report[1];
  assign o_done_size      = w_report[0] ? r_size[0] : (w_report[1] ? r_size[1] : 32'd0);
  assign o_done_count     = r_done_count;
  assign o_interrupt      = (r_done_count != 8'd0);
  assign o_busy           = !(&w_free) || !w_q_empty;

endmodule

// File: tb/tb_wb_ppfifo_2_mem_bank_ctrl.sv
// Bench for wb_ppfifo_2_mem_bank_ctrl: directed scenarios plus random traffic,
// every cycle compared against a queue-based model of the bank sequencer.
module tb_wb_ppfifo_2_mem_bank_ctrl;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_enable = 1'b0, i_flush = 1'b0, i_desc_stb = 1'b0;
  logic [31:0] i_desc_base = 32'd0, i_desc_size = 32'd0;
  logic [2:0]  o_desc_count;
  logic        o_desc_full, o_desc_err;
  logic [31:0] o_memory_0_base, o_memory_1_base, o_memory_0_size, o_memory_1_size;
  logic        o_memory_0_ready, o_memory_1_ready;
  logic        i_memory_0_finished = 1'b0, i_memory_1_finished = 1'b0;
  logic        o_done_stb, o_done_bank;
  logic [31:0] o_done_size;
  logic [7:0]  o_done_count;
  logic        i_done_ack = 1'b0;
  logic        o_interrupt, o_busy;

  always #5 clk = ~clk;

  wb_ppfifo_2_mem_bank_ctrl #(.DESC_DEPTH(DEPTH), .DESC_AW(2)) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_flush(i_flush),
    .i_desc_stb(i_desc_stb), .i_desc_base(i_desc_base), .i_desc_size(i_desc_size),
    .o_desc_count(o_desc_count), .o_desc_full(o_desc_full), .o_desc_err(o_desc_err),
    .o_memory_0_base(o_memory_0_base), .o_memory_1_base(o_memory_1_base),
    .o_memory_0_size(o_memory_0_size), .o_memory_1_size(o_memory_1_size),
    .o_memory_0_ready(o_memory_0_ready), .o_memory_1_ready(o_memory_1_ready),
    .i_memory_0_finished(i_memory_0_finished), .i_memory_1_finished(i_memory_1_finished),
    .o_done_stb(o_done_stb), .o_done_bank(o_done_bank), .o_done_size(o_done_size),
    .o_done_count(o_done_count), .i_done_ack(i_done_ack),
    .o_interrupt(o_interrupt), .o_busy(o_busy)
  );

  typedef struct { logic [31:0] base; logic [31:0] size; } desc_t;

  // Model: a bank is either free or holds a descriptor; m_age counts cycles since its ready pulse.
  desc_t       mq[$];
  bit          m_occ [2];
  bit          m_done [2];
  int          m_age [2];
  logic [31:0] m_base [2];
  logic [31:0] m_size [2];
  int          m_ptr, m_cnt;
  bit          m_err, m_valid;
  int          n_checks = 0, n_pass = 0, cyc = 0;
  logic [31:0] ready_bases[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    for (int b = 0; b < 2; b++) begin
      m_occ[b] = 1'b0; m_done[b] = 1'b0; m_age[b] = 0; m_base[b] = 32'd0; m_size[b] = 32'd0;
    end
    m_ptr = 0; m_err = 1'b0; m_cnt = 0;
  endtask

  function automatic bit fin(input int b);
    return (b == 0) ? i_memory_0_finished : i_memory_1_finished;
  endfunction

  task automatic model_step();
    int pick; bit rep0, rep1, rep, acc; desc_t d;
    if (rst) begin model_reset(); m_valid = 1'b1; return; end
    if (i_flush) begin
      mq.delete();
      for (int b = 0; b < 2; b++) begin
        m_occ[b] = 1'b0; m_done[b] = 1'b0; m_age[b] = 0; m_base[b] = 32'd0; m_size[b] = 32'd0;
      end
      m_ptr = 0; m_err = 1'b0;
      return;
    end
    rep0 = m_occ[0] && m_done[0];
    rep1 = !rep0 && m_occ[1] && m_done[1];
    rep  = rep0 || rep1;
    pick = -1;
    if (i_enable && mq.size() > 0) begin
      if (!m_occ[m_ptr]) pick = m_ptr;
      else if (!m_occ[1 - m_ptr]) pick = 1 - m_ptr;
    end
    for (int b = 0; b < 2; b++) begin
      if (m_occ[b]) begin
        if (m_done[b]) begin
          if ((b == 0 && rep0) || (b == 1 && rep1)) m_occ[b] = 1'b0;
        end else begin
          if (m_age[b] >= 2 && fin(b)) m_done[b] = 1'b1;
          m_age[b]++;
        end
      end
    end
    if (pick >= 0) begin
      d = mq.pop_front();
      m_occ[pick] = 1'b1; m_done[pick] = 1'b0; m_age[pick] = 0;
      m_base[pick] = d.base; m_size[pick] = d.size; m_ptr = 1 - pick;
    end
    acc = i_desc_stb && (i_desc_size != 32'd0) && (mq.size() < DEPTH);
    if (acc) begin d.base = i_desc_base; d.size = i_desc_size; mq.push_back(d); end
    m_err = i_desc_stb && !acc;
    if (rep && !i_done_ack) begin if (m_cnt < 255) m_cnt++; end
    else if (!rep && i_done_ack) begin if (m_cnt > 0) m_cnt--; end
  endtask

  task automatic compare();
    bit r0, r1;
    r0 = m_occ[0] && m_done[0];
    r1 = !r0 && m_occ[1] && m_done[1];
    check("desc_count", 32'(o_desc_count), 32'(mq.size()));
    check("desc_full", 32'(o_desc_full), 32'(mq.size() == DEPTH));
    check("desc_err", 32'(o_desc_err), 32'(m_err));
    check("mem0_base", o_memory_0_base, m_base[0]);
    check("mem1_base", o_memory_1_base, m_base[1]);
    check("mem0_size", o_memory_0_size, m_occ[0] ? m_size[0] : 32'd0);
    check("mem1_size", o_memory_1_size, m_occ[1] ? m_size[1] : 32'd0);
    check("mem0_ready", 32'(o_memory_0_ready), 32'(m_occ[0] && m_age[0] == 0));
    check("mem1_ready", 32'(o_memory_1_ready), 32'(m_occ[1] && m_age[1] == 0));
    check("done_stb", 32'(o_done_stb), 32'(r0 || r1));
    check("done_bank", 32'(o_done_bank), 32'(r1));
    check("done_size", o_done_size, r0 ? m_size[0] : (r1 ? m_size[1] : 32'd0));
    check("done_count", 32'(o_done_count), 32'(m_cnt));
    check("interrupt", 32'(o_interrupt), 32'(m_cnt != 0));
    check("busy", 32'(o_busy), 32'(m_occ[0] || m_occ[1] || mq.size() > 0));
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      compare();
      if (o_memory_0_ready) ready_bases.push_back(o_memory_0_base);
      if (o_memory_1_ready) ready_bases.push_back(o_memory_1_base);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] b, input logic [31:0] s);
    i_desc_stb = 1'b1; i_desc_base = b; i_desc_size = s;
    tick();
    i_desc_stb = 1'b0;
  endtask

  initial begin
    int t, t_ready;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_size0", o_memory_0_size, 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_cnt", 32'(o_done_count), 32'd0);

    // Two descriptors, bank 0 with a stale finished already high.
    push(32'h0, 32'd16);
    push(32'h200000, 32'd16);
    check("t1_qcount", 32'(o_desc_count), 32'd2);
    i_memory_0_finished = 1'b1;
    i_enable = 1'b1;
    t = 0; while (!o_memory_0_ready && t < 10) begin tick(); t++; end
    check("t1_ready0_seen", 32'(o_memory_0_ready), 32'd1);
    t_ready = cyc;
    tick();
    check("t1_ready1_next", 32'(o_memory_1_ready), 32'd1);
    t = 0; while (!o_done_stb && t < 10) begin tick(); t++; end
    check("t1_retire_latency", 32'(cyc - t_ready), 32'd3);
    check("t1_done_bank", 32'(o_done_bank), 32'd0);
    check("t1_done_size", o_done_size, 32'd16);
    i_memory_0_finished = 1'b0;
    tick();
    check("t1_irq", 32'(o_interrupt), 32'd1);
    i_done_ack = 1'b1; tick(); i_done_ack = 1'b0;
    check("t1_irq_clr", 32'(o_interrupt), 32'd0);
    i_memory_1_finished = 1'b1;
    t = 0; while (!o_done_stb && t < 10) begin tick(); t++; end
    check("t1_b1_bank", 32'(o_done_bank), 32'd1);
    check("t1_b1_size", o_done_size, 32'd16);
    i_memory_1_finished = 1'b0;
    tick();
    i_done_ack = 1'b1; tick(); i_done_ack = 1'b0;

    // Both banks finish in the same cycle.
    push(32'h3000, 32'd8);
    push(32'h4000, 32'd8);
    repeat (6) tick();
    i_memory_0_finished = 1'b1; i_memory_1_finished = 1'b1;
    tick();
    i_memory_0_finished = 1'b0; i_memory_1_finished = 1'b0;
    check("t3_stb_a", 32'(o_done_stb), 32'd1);
    check("t3_bank_a", 32'(o_done_bank), 32'd0);
    tick();
    check("t3_stb_b", 32'(o_done_stb), 32'd1);
    check("t3_bank_b", 32'(o_done_bank), 32'd1);
    tick();
    check("t3_stb_end", 32'(o_done_stb), 32'd0);
    check("t3_cnt", 32'(o_done_count), 32'd2);
    i_done_ack = 1'b1; tick(); tick(); i_done_ack = 1'b0;

    // Fill the queue with loading disabled; the fifth push is dropped.
    i_enable = 1'b0;
    for (int k = 0; k < 5; k++) push(32'h10000 + 32'(k) * 32'h1000, 32'd8);
    check("t2_err", 32'(o_desc_err), 32'd1);
    check("t2_count", 32'(o_desc_count), 32'd4);
    check("t2_full", 32'(o_desc_full), 32'd1);

    // Push and pop together while full, then keep the order across eight loads.
    ready_bases.delete();
    i_enable = 1'b1; i_memory_0_finished = 1'b1; i_memory_1_finished = 1'b1;
    push(32'h14000, 32'd8);
    check("t6_pushpop_err", 32'(o_desc_err), 32'd0);
    check("t6_pushpop_cnt", 32'(o_desc_count), 32'd4);
    for (int k = 5; k < 8; k++) begin
      t = 0; while (o_desc_full && t < 50) begin tick(); t++; end
      push(32'h10000 + 32'(k) * 32'h1000, 32'd8);
    end
    t = 0; while (o_busy && t < 100) begin tick(); t++; end
    check("t6_loads", 32'(ready_bases.size()), 32'd8);
    for (int k = 0; k < 8 && k < ready_bases.size(); k++)
      check("t6_order", ready_bases[k], 32'h10000 + 32'(k) * 32'h1000);
    check("t6_done_cnt", 32'(o_done_count), 32'd8);
    i_memory_0_finished = 1'b0; i_memory_1_finished = 1'b0;

    // Zero-size push is dropped.
    push(32'h5, 32'd0);
    check("t4_size0_err", 32'(o_desc_err), 32'd1);
    check("t4_size0_cnt", 32'(o_desc_count), 32'd0);

    // Flush with both banks active and two descriptors queued.
    for (int k = 0; k < 4; k++) push(32'h20000 + 32'(k) * 32'h1000, 32'd32);
    repeat (3) tick();
    check("t5_queued", 32'(o_desc_count), 32'd2);
    i_flush = 1'b1; tick(); i_flush = 1'b0;
    check("t5_size0", o_memory_0_size, 32'd0);
    check("t5_size1", o_memory_1_size, 32'd0);
    check("t5_qempty", 32'(o_desc_count), 32'd0);
    check("t5_no_stb", 32'(o_done_stb), 32'd0);
    check("t5_cnt_kept", 32'(o_done_count), 32'd8);

    // Saturate the completion counter.
    i_memory_0_finished = 1'b1; i_memory_1_finished = 1'b1;
    for (int i = 0; i < 1500; i++) push($urandom, 32'd1);
    t = 0; while (o_busy && t < 50) begin tick(); t++; end
    check("sat_255", 32'(o_done_count), 32'd255);
    i_done_ack = 1'b1; tick(); i_done_ack = 1'b0;
    check("sat_ack", 32'(o_done_count), 32'd254);

    // Random traffic with an occasional flush and one mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      i_desc_stb  = ($urandom_range(0, 2) == 0);
      i_desc_base = $urandom;
      i_desc_size = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 64));
      i_enable    = ($urandom_range(0, 9) != 0);
      i_memory_0_finished = ($urandom_range(0, 3) == 0);
      i_memory_1_finished = ($urandom_range(0, 3) == 0);
      i_done_ack  = ($urandom_range(0, 3) == 0);
      i_flush     = ($urandom_range(0, 199) == 0);
      rst         = (i == 1500);
      tick();
    end
    rst = 1'b0; i_desc_stb = 1'b0; i_flush = 1'b0; i_done_ack = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/wb_ppfifo_2_mem_bank_ctrl.md
Name: wb_ppfifo_2_mem_bank_ctrl

Overview:
- Sequences the two memory banks of the ping-pong-FIFO-to-memory writer. Host/CPU pushes buffer descriptors (base, size) into a small queue; this block loads them alternately into bank 0/1 (base, size, ready pulse) and watches each bank's finished flag.
- On finish it retires the bank, reports a completion record and raises a level interrupt.
- Sits between the wishbone slave register file and the writer's memory_0/memory_1 control ports.

Parameters:
- DESC_DEPTH, 4, descriptor queue entries (power of 2, ≥2)
- DESC_AW, 2, log2(DESC_DEPTH)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_enable  in  1  allow loading new descriptors into banks
- i_flush  in  1  abort: empty queue, retire both banks without completion
- i_desc_stb  in  1  push descriptor (one-cycle strobe)
- i_desc_base  in  32  descriptor base address (words)
- i_desc_size  in  32  descriptor size (words)
- o_desc_count  out  DESC_AW+1  queued (not yet loaded) descriptors
- o_desc_full  out  1  o_desc_count == DESC_DEPTH
- o_desc_err  out  1  one-cycle pulse: push dropped (full or size 0)
- o_memory_0_base / o_memory_1_base  out  32  bank base to writer
- o_memory_0_size / o_memory_1_size  out  32  bank size to writer; 0 = bank free
- o_memory_0_ready / o_memory_1_ready  out  1  one-cycle load pulse to writer
- i_memory_0_finished / i_memory_1_finished  in  1  writer: bank fully written
- o_done_stb  out  1  one-cycle completion pulse
- o_done_bank  out  1  bank that completed
- o_done_size  out  32  words written by that bank
- o_done_count  out  8  unacknowledged completions (saturates at 255)
- i_done_ack  in  1  decrement o_done_count by 1 (no change at 0)
- o_interrupt  out  1  level: o_done_count != 0
- o_busy  out  1  any bank not FREE or queue non-empty

Behaviour:
- Reset: queue empty, all outputs 0, both banks FREE, next-bank pointer = 0.
- Queue: FIFO; push accepted iff not full and i_desc_size != 0, else o_desc_err next cycle, queue unchanged. Push and pop in same cycle allowed when full (pop frees the slot first, so push is accepted); count unchanged.
- Per-bank FSM (independent, identical):
  - FREE: size = 0, ready = 0. Dispatch (below) loads base/size and goes to LOAD.
  - LOAD (1 cycle): ready = 1. Next state is ARM.
  - ARM (1 cycle): ready = 0. This cycle exists because the writer's pointer resets on ready, so finished is invalid in LOAD. Next state is ACTIVE.
  - ACTIVE: wait for i_memory_N_finished = 1. Then go to RETIRE.
  - RETIRE (1 cycle): size <= 0, o_done_stb = 1, o_done_bank = N, o_done_size = loaded size, o_done_count += 1. Next state is FREE.
- Dispatch: at most one load per cycle, only when i_enable = 1 and queue non-empty.
  - Bank chosen: next-bank pointer if that bank is FREE, else the other bank if FREE, else none.
  - On load, pop queue and set pointer = chosen bank ^ 1.
  - Loading overlaps the other bank's ACTIVE, so the writer switches banks without a gap.
- Both banks in RETIRE the same cycle: bank 0 reports that cycle, bank 1 is held one extra cycle in RETIRE and reports next cycle. No completion is lost.
- o_done_count: increment and i_done_ack in the same cycle leave it unchanged. It saturates at 255.
- i_enable low: no new loads; banks already LOAD/ARM/ACTIVE run to completion.
- i_flush (priority over all else):
  - next cycle queue empty, both banks FREE (size 0, ready 0);
  - no o_done_stb, pointer = 0, o_done_count preserved.
- Reset mid-operation: identical to reset values; the writer sees size 0 on both banks.

Test Plan:
- Push (0x0,16),(0x200000,16), i_enable=1 → bank0 ready pulse cycle T, bank1 ready T+1; bench finishes bank0 → o_done_stb, bank 0, size 16, o_interrupt=1; ack → o_interrupt=0.
- Push 5 descriptors with DESC_DEPTH=4 and i_enable=0 → 5th gives o_desc_err; o_desc_count=4, o_desc_full=1; push with size 0 → o_desc_err.
- Both banks assert finished the same cycle → two o_done_stb on consecutive cycles (bank 0 then bank 1); o_done_count=2.
- Stale finished held high through LOAD/ARM → no completion until ACTIVE; the first RETIRE occurs no earlier than 3 cycles after the ready pulse.
- i_flush during ACTIVE with 2 queued → next cycle sizes 0, o_desc_count=0, no o_done_stb, o_done_count unchanged.
- Push and pop in the same cycle while full → count stays 4, no o_desc_err, FIFO order preserved across 8 descriptors.
